// File: rtl/micro_pkg.sv
// Shared definitions for the multi-cycle MIPS microprogram sequencer.
//   - opcode constants for the IR[31:26] field
//   - microstate encodings S_FETCH..S_JUMP (4-bit micro-addresses)
//   - sequencing field codes used by the control store
//   - ALU-op select constants
package micro_pkg;

    localparam int UPC_W = 4;
    localparam int OP_W  = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [UPC_W-1:0] S_FETCH   = 4'd0;
    localparam logic [UPC_W-1:0] S_DECODE  = 4'd1;
    localparam logic [UPC_W-1:0] S_MEMADDR = 4'd2;
    localparam logic [UPC_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [UPC_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [UPC_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [UPC_W-1:0] S_EXEC    = 4'd6;
    localparam logic [UPC_W-1:0] S_RCOMP   = 4'd7;
    localparam logic [UPC_W-1:0] S_BRANCH  = 4'd8;
    localparam logic [UPC_W-1:0] S_JUMP    = 4'd9;

    typedef enum logic [1:0] {
        SEQ_INC   = 2'd0,
        SEQ_D1    = 2'd1,
        SEQ_D2    = 2'd2,
        SEQ_FETCH = 2'd3
    } seq_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/micro_dispatch.sv
// Dispatch ROMs for the microprogram sequencer (purely combinational).
//   op_code     in  6  IR[31:26]
//   disp1_addr  out 4  target of the DECODE dispatch
//   disp2_addr  out 4  target of the MEMADDR dispatch
//   illegal     out 1  op_code has no DECODE dispatch entry
module micro_dispatch
    import micro_pkg::*;
(
    input  logic [OP_W-1:0]  op_code,
    output logic [UPC_W-1:0] disp1_addr,
    output logic [UPC_W-1:0] disp2_addr,
    output logic             illegal
);

    always_comb begin
        disp1_addr = S_FETCH;
        illegal    = 1'b0;
        case (op_code)
            OP_RTYPE: disp1_addr = S_EXEC;
            OP_J:     disp1_addr = S_JUMP;
            OP_BEQ:   disp1_addr = S_BRANCH;
            OP_LW:    disp1_addr = S_MEMADDR;
            OP_SW:    disp1_addr = S_MEMADDR;
            default:  illegal    = 1'b1;
        endcase
    end

    // Only lw/sw reach MEMADDR, so the default is a silent return to fetch.
    always_comb begin
        disp2_addr = S_FETCH;
        case (op_code)
            OP_LW:   disp2_addr = S_MEMRD;
            OP_SW:   disp2_addr = S_MEMWR;
            default: disp2_addr = S_FETCH;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the multi-cycle MIPS core: micro-PC register,
// control store and next-address selection.
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   op_code    in  6   IR[31:26], used for dispatch
//   mem_ready  in  1   memory access complete; releases the wait states
//   upc        out 4   current micro-address
//   pc_write .. reg_dst  out 1  datapath controls
//   pc_source, alu_op, alu_src_b  out 2  datapath selects
//   illegal_op out 1   undecodable opcode seen in DECODE
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | read instruction, PC+4; waits on mem_ready
// DECODE  | branch target calc, dispatch on opcode
// MEMADDR | effective address, dispatch lw/sw
// MEMRD   | data read; waits on mem_ready
// MEMWB   | load writeback to rt
// MEMWR   | data write; waits on mem_ready
// EXEC    | R-type ALU operation
// RCOMP   | R-type writeback to rd
// BRANCH  | beq compare, conditional PC write
// JUMP    | unconditional PC write
// 10..15  | never entered; all controls off, return to FETCH
module micro_sequencer
    import micro_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op_code,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             illegal_op
);

    logic [UPC_W-1:0] upc_next;
    logic [UPC_W-1:0] disp1_addr;
    logic [UPC_W-1:0] disp2_addr;
    logic             disp_illegal;
    seq_t             seq;
    logic             wait_mem;

    micro_dispatch u_dispatch (
        .op_code    (op_code),
        .disp1_addr (disp1_addr),
        .disp2_addr (disp2_addr),
        .illegal    (disp_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc <= S_FETCH;
        end else begin
            upc <= upc_next;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_op        = ALU_ADD;
        alu_src_b     = 2'b00;
        illegal_op    = 1'b0;
        seq           = SEQ_FETCH;
        wait_mem      = 1'b0;

        case (upc)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC only latch once the instruction word is valid.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                seq       = SEQ_INC;
                wait_mem  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_op     = ALU_ADD;
                illegal_op = disp_illegal;
                seq        = SEQ_D1;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                seq       = SEQ_D2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                seq      = SEQ_INC;
                wait_mem = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                wait_mem  = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = ALU_FUNCT;
                seq       = SEQ_INC;
            end
            S_RCOMP: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: seq = SEQ_FETCH;
        endcase

        if (wait_mem && !mem_ready) begin
            upc_next = upc;
        end else begin
            case (seq)
                SEQ_INC:   upc_next = upc + 4'd1;
                SEQ_D1:    upc_next = disp1_addr;
                SEQ_D2:    upc_next = disp2_addr;
                default:   upc_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    logic       clk;
    logic       rst;
    logic [5:0] op_code;
    logic       mem_ready;
    logic [3:0] upc;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         st;
        logic       rdy;
        logic [5:0] op;
    } exp_t;

    exp_t exp_q[$];

    micro_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .op_code       (op_code),
        .mem_ready     (mem_ready),
        .upc           (upc),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Micro-address path of one instruction with no wait states, -1 = done.
    function automatic int path_step(input logic [5:0] op, input int i);
        int p[5];
        case (op)
            6'b000000: p = '{0, 1, 6, 7, -1};
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5, -1};
            6'b000100: p = '{0, 1, 8, -1, -1};
            6'b000010: p = '{0, 1, 9, -1, -1};
            default:   p = '{0, 1, -1, -1, -1};
        endcase
        return (i < 5) ? p[i] : -1;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b000010 || op == 6'b000100 ||
               op == 6'b100011 || op == 6'b101011;
    endfunction

    // Expected outputs packed as {pc_write, pc_write_cond, i_or_d, mem_read,
    // mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst,
    // pc_source, alu_op, alu_src_b, illegal_op}.
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
        logic pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill;
        logic [1:0] ps, ao, asb;
        {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill} = '0;
        ps = 2'b00; ao = 2'b00; asb = 2'b00;
        case (st)
            0: begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1: begin asb = 2'b11; ill = !is_legal(op); end
            2: begin asa = 1; asb = 2'b10; end
            3: begin mr = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iod = 1; end
            6: begin asa = 1; ao = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ps, ao, asb, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared at negedge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("upc", {28'd0, upc}, r.st);
                check($sformatf("ctrl_st%0d", r.st),
                      {15'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst,
                       pc_source, alu_op, alu_src_b, illegal_op},
                      {15'd0, exp_ctrl(r.st, r.rdy, r.op)});
            end
        end
    end

    // Drive one cycle (entered at posedge+1) and record what must be seen.
    task automatic drive_cycle(input int st, input logic rdy, input logic [5:0] op);
        exp_t e;
        op_code   = op;
        mem_ready = rdy;
        e.st = st; e.rdy = rdy; e.op = op;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // mode 0: mem_ready always 1; mode 1: random mem_ready.
    // low5 forces that many mem_ready=0 cycles in MEMWR.
    task automatic run_instr(input logic [5:0] op, input int mode, input int low5);
        int   idx;
        int   st;
        logic rdy;
        int   low_left;
        idx = 0;
        low_left = low5;
        st = path_step(op, 0);
        while (st >= 0) begin
            rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (st == 5 && low_left > 0) begin
                rdy = 1'b0;
                low_left--;
            end
            drive_cycle(st, rdy, op);
            if (!((st == 0 || st == 3 || st == 5) && !rdy)) begin
                idx++;
                st = path_step(op, idx);
            end
        end
    endtask

    initial begin
        logic [5:0] legal_ops[5];
        logic [5:0] op;
        legal_ops = '{6'b000000, 6'b000010, 6'b000100, 6'b100011, 6'b101011};

        rst       = 1'b1;
        mem_ready = 1'b0;
        op_code   = 6'b100011;
        @(posedge clk);
        #1;
        drive_cycle(0, 1'b0, 6'b100011);
        drive_cycle(0, 1'b1, 6'b100011);
        rst = 1'b0;

        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 2);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);

        // Abort a load while stalled in MEMRD.
        drive_cycle(0, 1'b1, 6'b100011);
        drive_cycle(1, 1'b1, 6'b100011);
        drive_cycle(2, 1'b1, 6'b100011);
        op_code   = 6'b100011;
        mem_ready = 1'b0;
        begin
            exp_t e;
            e.st = 3; e.rdy = 1'b0; e.op = 6'b100011;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_upc", {28'd0, upc}, 32'd0);
        check("rst_async_mem_read", {31'd0, mem_read}, 32'd1);
        check("rst_async_i_or_d", {31'd0, i_or_d}, 32'd0);
        check("rst_async_strobes", {28'd0, ir_write, pc_write, mem_write, reg_write}, 32'd0);
        @(posedge clk);
        #1;
        drive_cycle(0, 1'b0, 6'b101011);
        rst = 1'b0;
        run_instr(6'b101011, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 4)];
            run_instr(op, 1, 0);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the multi-cycle MIPS core. Holds the 4-bit micro-PC (uPC) and selects the next micro-address each cycle by increment, opcode dispatch, or return to fetch. It emits the datapath control word for the current microinstruction and stalls on memory states until the memory port reports ready. It sits between the instruction register opcode field and every datapath control input.

## Interface
- No parameters; widths are fixed by the shared package.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_code  in  6  IR[31:26]; stable from the cycle after a completed fetch.
- mem_ready  in  1  memory port finished the current access.
- upc  out  4  current micro-address, for debug and bench observation.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst  out  1 each  datapath controls.
- pc_source, alu_op, alu_src_b  out  2 each  datapath mux and ALU selects.
- illegal_op  out  1  one-cycle pulse when an undecodable opcode is dispatched.

## Operation
- Microstates and the controls each asserts (any control not listed is 0):
  - 0 FETCH: mem_read; alu_src_b=01; pc_source=00. ir_write and pc_write are asserted only while mem_ready=1.
  - 1 DECODE: alu_src_b=11; alu_op=00.
  - 2 MEMADDR: alu_src_a; alu_src_b=10.
  - 3 MEMRD: mem_read; i_or_d.
  - 4 MEMWB: reg_write; mem_to_reg; reg_dst=0.
  - 5 MEMWR: mem_write; i_or_d.
  - 6 EXEC: alu_src_a; alu_src_b=00; alu_op=10.
  - 7 RCOMP: reg_write; reg_dst.
  - 8 BRANCH: alu_src_a; alu_op=01; pc_write_cond; pc_source=01.
  - 9 JUMP: pc_write; pc_source=10.
- Sequencing field per state:
  - 0: SEQ, waits on mem_ready.
  - 1: DISP1.
  - 2: DISP2.
  - 3: SEQ, waits on mem_ready.
  - 5: FETCH, waits on mem_ready.
  - 6: SEQ.
  - 4, 7, 8, 9: FETCH.
- Sequencing actions:
  - SEQ: next uPC = uPC+1.
  - FETCH: next uPC = 0.
- DISP1 mapping:
  - 000000 → 6
  - 000010 → 9
  - 000100 → 8
  - 100011 → 2
  - 101011 → 2
  - any other opcode → 0, with illegal_op=1 during that DECODE cycle.
- DISP2 mapping:
  - 100011 → 3
  - 101011 → 5
  - any other opcode → 0. This case is unreachable in normal operation; no flag is raised.
- Wait rule: in states 0, 3 and 5, uPC holds while mem_ready=0.
- Encodings 10–15 are never entered. If one is entered, all controls are 0 and the next uPC is 0.

## Timing
- Moore outputs: every control is a combinational function of uPC. The only exceptions are ir_write and pc_write in FETCH, which are also gated by mem_ready.
- uPC updates on the rising clk edge. The dispatch decision uses op_code sampled at that edge.
- Reset: uPC=0 immediately and asynchronously. Outputs during reset are therefore the FETCH word with mem_ready gating:
  - mem_read=1, alu_src_b=01.
  - ir_write and pc_write follow mem_ready.
  - all other outputs 0; illegal_op=0.
- Reset asserted mid-instruction aborts it. No write strobe is asserted in the cycle after release unless FETCH with mem_ready=1.
- Cycle counts with mem_ready held at 1:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
- Each cycle mem_ready=0 in states 0, 3 or 5 adds one cycle.
- mem_ready is ignored in all other states.

## Structure
- Shared package `micro_pkg` holds:
  - opcode constants: OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW;
  - microstate localparams S_FETCH..S_JUMP;
  - sequencing codes SEQ_INC, SEQ_D1, SEQ_D2, SEQ_FETCH;
  - ALU-op constants.
- Sub-module `micro_dispatch`: purely combinational. Takes op_code and returns disp1_addr[3:0], disp2_addr[3:0] and illegal.
- The top level contains the uPC register, the control-store case and the next-address mux.

## Test plan
- Reset with mem_ready=0 → upc=0, mem_read=1, alu_src_b=01, ir_write=0, pc_write=0, illegal_op=0. Release reset and raise mem_ready → upc sequence 0,1 with ir_write=pc_write=1 in the FETCH cycle.
- lw (op 100011), mem_ready=1 → upc 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0.
- sw (op 101011), mem_ready low for 2 cycles in state 5 → upc 0,1,2,5,5,5,0. mem_write=1 and i_or_d=1 in all three state-5 cycles.
- R-type (000000) then beq (000100) then j (000010) back-to-back → upc 0,1,6,7,0,1,8,0,1,9,0. alu_op=10 in 6, pc_write_cond=1 with pc_source=01 in 8, pc_write=1 with pc_source=10 in 9.
- Illegal op 111111 → upc 0,1,0, with illegal_op=1 only in the DECODE cycle.
- Assert rst while upc=3 with mem_ready=0 → upc=0 in the same cycle, before the next clk edge. After release, normal fetch resumes.
